// File: rtl/uart_rx_mmio_if.sv
// uart_rx_mmio_if: pipeline data-bus bundle for the memory-mapped UART receiver.
//   mem_valid  : access strobe             (master -> slave)
//   mem_write  : 1 = write, 0 = read       (master -> slave)
//   mem_wmask  : byte write mask           (master -> slave)
//   mem_wdata  : write data                (master -> slave)
//   mem_addr   : byte address              (master -> slave)
//   mem_rdata  : read data, one cycle late (slave -> master)
//   rsel       : read-hit flag for the mux (slave -> master)
interface uart_rx_mmio_if;
  logic        mem_valid;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        rsel;

  modport master (
    output mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
    input  mem_rdata, rsel
  );

  modport slave (
    input  mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
    output mem_rdata, rsel
  );
endinterface

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: memory-mapped 8N1 UART receiver with a small byte FIFO.
//   clk      : clock, rising edge
//   rstn     : synchronous active-low reset
//   bus      : data-bus slave (see uart_rx_mmio_if); RXDATA at BASE+0x04 pops,
//              STATUS at BASE+0x10 = {frame_err, overrun, rx_avail, tx_ready}
//   rx       : asynchronous serial input, idle high
//   tx_ready : transmitter-ready flag mirrored into STATUS bit0
module uart_rx_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h7000_0000,
  parameter int unsigned CLK_DIV   = 434,
  parameter int unsigned FIFO_AW   = 2
) (
  input  logic          clk,
  input  logic          rstn,
  uart_rx_mmio_if.slave bus,
  input  logic          rx,
  input  logic          tx_ready
);
  localparam int unsigned       CW          = $clog2(CLK_DIV);
  localparam int unsigned       DEPTH       = 1 << FIFO_AW;
  localparam logic [CW-1:0]     HALF_LOAD   = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0]     BIT_LOAD    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]     CNT_ZERO    = CW'(0);
  localparam logic [CW-1:0]     CNT_ONE     = CW'(1);
  localparam logic [FIFO_AW:0]  FULL_CNT    = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]  CNT_EMPTY   = (FIFO_AW + 1)'(0);
  localparam logic [31:0]       RXDATA_ADDR = BASE_ADDR + 32'h0000_0004;
  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'h0000_0010;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic               r_rx_meta, r_rs;
  state_t             r_state, w_state_n;
  logic [CW-1:0]      r_cnt, w_cnt_n;
  logic [2:0]         r_idx, w_idx_n;
  logic [7:0]         r_shift, w_shift_n;
  logic               w_push, w_frame_set;

  logic [7:0]         r_fifo [0:DEPTH-1];
  logic [FIFO_AW-1:0] r_wp, r_rp;
  logic [FIFO_AW:0]   r_count;
  logic               r_overrun, r_frame_err;
  logic [31:0]        r_rdata;
  logic               r_rsel;

  logic               w_empty, w_full, w_hit_rx, w_hit_st, w_rd_hit, w_pop;
  logic               w_push_ok, w_ovr_set, w_st_wr, w_clr_ovr, w_clr_fe;
  logic [31:0]        w_status, w_rd_value;
  logic               w_unused_bits;

  assign w_empty   = (r_count == CNT_EMPTY);
  assign w_full    = (r_count == FULL_CNT);
  assign w_hit_rx  = (bus.mem_addr == RXDATA_ADDR);
  assign w_hit_st  = (bus.mem_addr == STATUS_ADDR);
  assign w_rd_hit  = bus.mem_valid & ~bus.mem_write & (w_hit_rx | w_hit_st);
  assign w_pop     = bus.mem_valid & ~bus.mem_write & w_hit_rx & ~w_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovr_set = w_push & w_full & ~w_pop;
  assign w_st_wr   = bus.mem_valid & bus.mem_write & w_hit_st & bus.mem_wmask[0];
  assign w_clr_ovr = w_st_wr & bus.mem_wdata[2];
  assign w_clr_fe  = w_st_wr & bus.mem_wdata[3];
  assign w_status  = {28'h000_0000, r_frame_err, r_overrun, ~w_empty, tx_ready};
  assign w_unused_bits = &{1'b0, bus.mem_wdata[31:4], bus.mem_wdata[1:0], bus.mem_wmask[3:1]};

  assign bus.mem_rdata = r_rdata;
  assign bus.rsel      = r_rsel;

  // rx synchroniser, receive FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rx_meta <= 1'b1;
      r_rs      <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= CNT_ZERO;
      r_idx     <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      r_rx_meta <= rx;
      r_rs      <= r_rx_meta;
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_idx     <= w_idx_n;
      r_shift   <= w_shift_n;
    end
  end

  // receive FSM next-state, bit timing and byte assembly
  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_idx_n     = r_idx;
    w_shift_n   = r_shift;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rs) begin
          w_cnt_n   = HALF_LOAD;
          w_state_n = S_START;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_START: begin
        if (r_cnt != CNT_ZERO) begin
          w_cnt_n = r_cnt - CNT_ONE;
        end else if (!r_rs) begin
          w_cnt_n   = BIT_LOAD;
          w_idx_n   = 3'd0;
          w_state_n = S_DATA;
        end else begin
          // start bit vanished by mid-bit: treat as a glitch
          w_state_n = S_IDLE;
        end
      end
      S_DATA: begin
        if (r_cnt != CNT_ZERO) begin
          w_cnt_n = r_cnt - CNT_ONE;
        end else begin
          w_shift_n[r_idx] = r_rs;
          w_cnt_n          = BIT_LOAD;
          if (r_idx == 3'd7) begin
            w_state_n = S_STOP;
          end else begin
            w_idx_n = r_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (r_cnt != CNT_ZERO) begin
          w_cnt_n = r_cnt - CNT_ONE;
        end else if (r_rs) begin
          w_push    = 1'b1;
          w_state_n = S_IDLE;
        end else begin
          w_frame_set = 1'b1;
          w_state_n   = S_BREAK;
        end
      end
      S_BREAK: begin
        if (r_rs) begin
          w_state_n = S_IDLE;
        end else begin
          w_state_n = S_BREAK;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // FIFO storage write port (contents need no reset; count gates visibility)
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo[r_wp] <= r_shift;
    end else begin
      r_fifo[r_wp] <= r_fifo[r_wp];
    end
  end

  // FIFO pointers, occupancy count and sticky error flags
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= CNT_EMPTY;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop)     r_rp <= r_rp + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // a new error event in the same cycle as a clear wins, so it is never lost
      if (w_ovr_set)      r_overrun <= 1'b1;
      else if (w_clr_ovr) r_overrun <= 1'b0;
      else                r_overrun <= r_overrun;
      if (w_frame_set)    r_frame_err <= 1'b1;
      else if (w_clr_fe)  r_frame_err <= 1'b0;
      else                r_frame_err <= r_frame_err;
    end
  end

  // read-data selection for the accessed register
  always_comb begin
    w_rd_value = w_status;
    if (w_hit_rx) begin
      if (w_empty) begin
        w_rd_value = 32'hFFFF_FFFF;
      end else begin
        w_rd_value = {24'h00_0000, r_fifo[r_rp]};
      end
    end else begin
      w_rd_value = w_status;
    end
  end

  // one-cycle registered read response; rdata holds between hitting reads
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rdata <= 32'h0000_0000;
      r_rsel  <= 1'b0;
    end else begin
      r_rsel <= w_rd_hit;
      if (w_rd_hit) r_rdata <= w_rd_value;
      else          r_rdata <= r_rdata;
    end
  end
endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb_uart_rx_mmio: scoreboard bench for uart_rx_mmio with CLK_DIV=8.
// Bus reads push their expected value into a queue; a negedge monitor pops and
// compares whenever rsel is high.
module tb_uart_rx_mmio;
  localparam logic [31:0] BASE   = 32'h7000_0000;
  localparam logic [31:0] A_RX   = BASE + 32'h4;
  localparam logic [31:0] A_ST   = BASE + 32'h10;
  localparam int          DIV    = 8;

  logic clk, rstn, rx, tx_ready;
  uart_rx_mmio_if bus();

  uart_rx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_AW(2)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .rx(rx), .tx_ready(tx_ready)
  );

  typedef struct { string name; logic [31:0] exp; } exp_t;
  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: every presented read response is matched against the scoreboard
  always @(negedge clk) begin
    if (bus.rsel === 1'b1) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsel: got rdata %h with no read outstanding", bus.mem_rdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.mem_rdata !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.name, bus.mem_rdata, e.exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_cycle(input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] mask);
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b1;
    bus.mem_write = wr;
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    bus.mem_wmask = mask;
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    q.push_back(e);
    bus_cycle(1'b0, addr, 32'h0, 4'h0);
  endtask

  // frame: start, 8 data bits LSB first, stop; then extra_low bit-times of low
  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low);
    rx = 1'b0;
    wait_clks(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(DIV);
    end
    rx = stop;
    wait_clks(DIV);
    if (extra_low > 0) begin
      rx = 1'b0;
      wait_clks(DIV * extra_low);
    end
    rx = 1'b1;
  endtask

  initial begin
    logic [7:0] bytes [5];
    rstn = 1'b0;
    rx = 1'b1;
    tx_ready = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_wmask = 4'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_addr  = 32'h0;
    wait_clks(3);
    check("reset_rdata", bus.mem_rdata, 32'h0);
    check("reset_rsel", {31'h0, bus.rsel}, 32'h0);
    rstn = 1'b1;
    wait_clks(2);

    // reset state and empty read
    bus_read("status_after_reset", A_ST, 32'h1);
    bus_read("rxdata_empty", A_RX, 32'hFFFF_FFFF);
    wait_clks(1);
    check("rsel_one_cycle", {31'h0, bus.rsel}, 32'h0);
    bus_cycle(1'b0, BASE, 32'h0, 4'h0);
    check("base0_not_decoded", {31'h0, bus.rsel}, 32'h0);
    tx_ready = 1'b0;
    bus_read("status_tx_not_ready", A_ST, 32'h0);
    tx_ready = 1'b1;

    // single byte
    send_frame(8'h55, 1'b1, 0);
    bus_read("status_one_byte", A_ST, 32'h3);
    bus_read("rxdata_55", A_RX, 32'h55);
    bus_read("status_after_pop", A_ST, 32'h1);

    // glitch rejection, then confirm the receiver still works
    rx = 1'b0;
    wait_clks(2);
    rx = 1'b1;
    wait_clks(12);
    bus_read("status_after_glitch", A_ST, 32'h1);
    send_frame(8'h3C, 1'b1, 0);
    bus_read("rxdata_after_glitch", A_RX, 32'h3C);

    // overrun: five bytes into a four-deep FIFO
    bytes = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    for (int i = 0; i < 5; i++) send_frame(bytes[i], 1'b1, 0);
    bus_read("status_overrun", A_ST, 32'h7);
    for (int i = 0; i < 4; i++) bus_read("rxdata_overrun_order", A_RX, {24'h0, bytes[i]});
    bus_read("rxdata_overrun_empty", A_RX, 32'hFFFF_FFFF);
    bus_cycle(1'b1, A_ST, 32'h4, 4'h0);
    bus_read("status_masked_clear", A_ST, 32'h5);
    bus_cycle(1'b1, A_RX, 32'h4, 4'h1);
    bus_read("status_wrong_addr_clear", A_ST, 32'h5);
    bus_cycle(1'b1, A_ST, 32'h4, 4'h1);
    bus_read("status_overrun_cleared", A_ST, 32'h1);

    // framing error then a good byte
    send_frame(8'hA5, 1'b0, 3);
    wait_clks(8);
    send_frame(8'h5A, 1'b1, 0);
    bus_read("status_frame_err", A_ST, 32'hB);
    bus_read("rxdata_after_break", A_RX, 32'h5A);
    bus_cycle(1'b1, A_ST, 32'h8, 4'h1);
    bus_read("status_fe_cleared", A_ST, 32'h1);

    // full FIFO with a pop in the same cycle the stop bit is accepted
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 0; i < 4; i++) send_frame(bytes[i], 1'b1, 0);
    bus_read("status_full", A_ST, 32'h3);
    fork
      send_frame(8'h66, 1'b1, 0);
      begin
        wait_clks(77);
        bus_read("rxdata_pop_at_push", A_RX, 32'h11);
      end
    join
    wait_clks(2);
    bus_read("status_no_overrun", A_ST, 32'h3);
    for (int i = 1; i < 5; i++) bus_read("rxdata_push_pop_order", A_RX, {24'h0, bytes[i]});
    bus_read("rxdata_push_pop_empty", A_RX, 32'hFFFF_FFFF);

    // reset during bit 4 of a frame, with a byte already queued
    send_frame(8'h77, 1'b1, 0);
    fork
      send_frame(8'hF0, 1'b1, 0);
      begin
        wait_clks(43);
        rstn = 1'b0;
        wait_clks(2);
        rstn = 1'b1;
      end
    join
    check("midframe_reset_rdata", bus.mem_rdata, 32'h0);
    wait_clks(20);
    bus_read("status_after_midframe_reset", A_ST, 32'h1);
    bus_read("rxdata_after_midframe_reset", A_RX, 32'hFFFF_FFFF);

    // drain: every issued read must have been answered
    for (int i = 0; i < 10 && q.size() != 0; i++) wait_clks(1);
    check("scoreboard_drained", q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_mmio.md
Name: uart_rx_mmio

Overview:
- Memory-mapped 8N1 UART receiver. It is the receive-direction counterpart of the putchar/status UART at 0x7000_0000.
- Deserialises the `rx` pin into a small byte FIFO.
- Responds to Pipeline data-bus reads with data and status, using the same one-cycle read latency as the other memories.
- Its `mem_rdata` is muxed into the core's read path by the system when `rsel` is high.

Parameters:
- BASE_ADDR, 32'h7000_0000, UART register block base.
- CLK_DIV, 434, clocks per bit (50 MHz / 115200); legal values are 4 or more.
- FIFO_AW, 2, log2 of the receive FIFO depth (default depth is 4).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rstn  input  1  synchronous active-low reset.
- mem_valid  input  1  bus access strobe.
- mem_write  input  1  1 = write, 0 = read.
- mem_wmask  input  4  byte write mask.
- mem_wdata  input  32  write data.
- mem_addr  input  32  byte address.
- mem_rdata  output  32  read data, valid the cycle after the access.
- rsel  output  1  high the cycle after a read that hit this block.
- rx  input  1  asynchronous serial input; idle level is high.
- tx_ready  input  1  transmitter-ready flag, mirrored into the status register.

Behaviour:
- Register map:
  - BASE+0x04 RXDATA (read-only, popping).
  - BASE+0x10 STATUS:
    - bit0 = tx_ready
    - bit1 = rx_avail (FIFO not empty)
    - bit2 = overrun (sticky)
    - bit3 = frame_err (sticky)
    - all other bits 0
- Decoding uses the full 32-bit address compare. Any other address is ignored; this block does not decode BASE+0x00.
- Read timing:
  - On a cycle with mem_valid & !mem_write & decode hit, the selected value is registered into mem_rdata and rsel is set to 1 on the next cycle.
  - rsel drops after one cycle unless another hitting read occurs.
  - mem_rdata holds its value until the next hitting read.
- RXDATA read:
  - FIFO non-empty: return {24'h0, head byte} and pop in the access cycle.
  - FIFO empty: return 32'hFFFF_FFFF, no pop.
- STATUS read: returns the live values from the access cycle and has no side effect.
- STATUS write: a write with mem_wmask[0]=1 and mem_wdata[2]=1 clears overrun; mem_wdata[3]=1 clears frame_err. Writes to other addresses are ignored.
- rx synchroniser: 2 flops, reset to 1. The FSM uses only the synchronised value rs.
- FSM states are IDLE, START, DATA, STOP, BREAK. The bit counter counts clocks and the index counts bits 0..7.
  - IDLE: when rs==0, load counter = CLK_DIV/2 - 1 and go to START.
  - START: at counter 0, resample rs.
    - rs==0: load CLK_DIV-1, index 0, go to DATA.
    - rs==1: glitch, go to IDLE with no error.
  - DATA: at counter 0, shift rs into bit[index] (LSB first) and reload CLK_DIV-1. After index 7, go to STOP.
  - STOP: at counter 0, sample rs.
    - rs==1: push the byte and go to IDLE.
    - rs==0: set frame_err, discard the byte, go to BREAK.
  - BREAK: stay until rs==1, then go to IDLE.
- Push/pop rules:
  - Push when full and no pop in the same cycle: set overrun, drop the new byte, keep FIFO contents.
  - Push and pop in the same cycle: both take effect; count is unchanged; no overrun even when full.
  - Pointers wrap modulo 2^FIFO_AW. Count is FIFO_AW+1 bits wide.
- Reset (rstn=0 at a clock edge):
  - FSM returns to IDLE and the FIFO is emptied.
  - overrun=0, frame_err=0, mem_rdata=0, rsel=0, synchroniser=1.
  - Reset in the middle of a frame abandons that frame. The remainder of the frame is treated as fresh line activity after reset.
- Frame timing: 1 start + 8 data + 1 stop bit. rx_avail rises at most CLK_DIV/2 + 9*CLK_DIV + 3 clocks after the start-bit falling edge.

Test Plan:
- Reset and empty read, CLK_DIV=8: release reset, then read STATUS → 0x1 (tx_ready=1). Read RXDATA → 0xFFFF_FFFF; rsel=1 for exactly one cycle.
- Single byte: send 0x55 framed → STATUS=0x3. RXDATA read → 0x0000_0055, then STATUS=0x1.
- Glitch rejection: drive rx low for 2 clocks, then high → no byte received, STATUS=0x1, FSM back in IDLE.
- Overrun: send 0x41, 0x42, 0x43, 0x44, 0x45 with no reads → STATUS=0x7. Reads return 0x41, 0x42, 0x43, 0x44, then 0xFFFF_FFFF. Write 0x4 to STATUS → STATUS=0x1.
- Framing error: send 0xA5 with stop bit 0, hold rx low for 3 bit times, then high, then send 0x5A → STATUS=0xB. Read → 0x5A (0xA5 discarded). Write 0x8 to STATUS clears frame_err.
- Boundary conditions:
  - With the FIFO full, pop by reading RXDATA in the same cycle the stop bit is accepted → no overrun; the FIFO keeps 4 entries in order.
  - Assert rstn=0 during bit 4 of a frame → FIFO empty, no byte delivered.
